// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type, instruction cache FSM states,
// address slicing view and default cache geometry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

  // Byte address viewed as {tag, idx, byte offset} for the default geometry
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_frames.sv
// Frame storage for the direct-mapped instruction cache: valid bits
// (reset-cleared), tag and data arrays with one write port and a
// combinational lookup port.
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] ridx,
  input  logic [TAG_W-1:0] rtag,
  output logic             rhit,
  output word_t            rdata,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  word_t            wdata
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  word_t            data [SETS];

  // Valid bits: cleared by reset, set when a frame is filled
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= '0;
    end else if (wen) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; valid gates their use
  always_ff @(posedge CLK) begin
    if (wen) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end

  // Combinational lookup of the indexed frame
  always_comb begin
    rhit  = valid[ridx] && (tags[ridx] == rtag);
    rdata = data[ridx];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache.
// Hits are answered combinationally in IDLE; a miss latches the address and
// performs a blocking single-word fill from memory in FETCH.
// Optional feature macro: ICACHE_STATS_EN enables hit/miss counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t            state;
  logic [TAG_W+IDX_W-1:0]   fill_q;
  logic [IDX_W-1:0]         lidx;
  logic [TAG_W-1:0]         ltag;
  logic                     rhit;
  word_t                    rdata;
  logic                     fill_done;
  logic                     miss;
  logic                     unused_boff;

  assign lidx        = imemaddr[IDX_W+1:2];
  assign ltag        = imemaddr[31:IDX_W+2];
  assign unused_boff = ^imemaddr[1:0];

  icache_frames #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .CLK   (CLK),
    .RST   (RST),
    .ridx  (lidx),
    .rtag  (ltag),
    .rhit  (rhit),
    .rdata (rdata),
    .wen   (fill_done),
    .widx  (fill_q[IDX_W-1:0]),
    .wtag  (fill_q[TAG_W+IDX_W-1:IDX_W]),
    .wdata (iload)
  );

  // Fetch-side response, memory request and fill strobe decoded from state
  always_comb begin
    ihit      = (state == IDLE) && imemREN && rhit;
    miss      = (state == IDLE) && imemREN && !rhit;
    imemload  = ihit ? rdata : '0;
    iREN      = (state == FETCH);
    iaddr     = iREN ? {fill_q, 2'b00} : '0;
    fill_done = (state == FETCH) && !iwait;
  end

  // Miss/fill FSM; the fill always completes for the latched address
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      fill_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            fill_q <= {ltag, lidx};
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // Hit/miss statistics, wrapping modulo 2^32
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed scenarios followed by randomized traffic,
// checked against a behavioural cache model with a hit-data scoreboard.
module tb_icache;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache #(.SETS(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;
  word_t sbq[$];

  // Behavioural model: which word address each frame holds, and what data
  bit          known = 0;
  bit          mfetch = 0;
  logic [29:0] mfaddr = '0;
  bit          mval  [16];
  logic [29:0] mline [16];
  word_t       mdat  [16];
  int unsigned mhits = 0;
  int unsigned mmiss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after negedge, check, then advance model
  task automatic cycle(input bit rst, input bit ren, input logic [31:0] addr,
                       input bit wt, input logic [31:0] ld);
    int          i;
    bit          eh;
    logic [31:0] eia;
    @(negedge CLK);
    RST = rst; imemREN = ren; imemaddr = addr; iwait = wt; iload = ld;
    #1;
    i   = int'(addr[5:2]);
    eh  = !mfetch && ren && mval[i] && (mline[i] == addr[31:2]);
    eia = mfetch ? {mfaddr, 2'b00} : 32'h0;
    if (known) begin
      chk("ihit", {31'b0, ihit}, {31'b0, eh});
      chk("iREN", {31'b0, iREN}, {31'b0, mfetch});
      chk("iaddr", iaddr, eia);
      if (!eh) chk("imemload_idle", imemload, 32'h0);
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, mhits);
      chk("miss_count", miss_count, mmiss);
`else
      chk("hit_count", hit_count, 32'h0);
      chk("miss_count", miss_count, 32'h0);
`endif
      if (eh) sbq.push_back(mdat[i]);
    end
    if (rst) begin
      known = 1; mfetch = 0; mhits = 0; mmiss = 0;
      foreach (mval[k]) mval[k] = 0;
    end else if (known) begin
      if (eh) mhits++;
      if (mfetch) begin
        if (!wt) begin
          mval[mfaddr[3:0]]  = 1;
          mline[mfaddr[3:0]] = mfaddr;
          mdat[mfaddr[3:0]]  = ld;
          mfetch = 0;
        end
      end else if (ren && !eh) begin
        mfetch = 1;
        mfaddr = addr[31:2];
        mmiss++;
      end
    end
  endtask

  // Scoreboard monitor: consumes one expected word per presented hit
  initial begin
    word_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (ihit === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++; fails++;
          $display("FAIL sb_unexpected_hit got=%h exp=none t=%0t", imemload, $time);
        end else begin
          e = sbq.pop_front();
          chk("sb_imemload", imemload, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    // 1: cold miss on 0x40, three wait cycles, fill
    cycle(0, 1, 32'h40, 1, 0);
    repeat (3) cycle(0, 1, 32'h40, 1, 0);
    cycle(0, 1, 32'h40, 0, 32'h2001_0005);
    cycle(0, 1, 32'h40, 1, 0);
    chk("t1_imemload", imemload, 32'h2001_0005);
    // 2: re-fetch hits with no memory request
    cycle(0, 1, 32'h40, 1, 0);
    chk("t2_iREN", {31'b0, iREN}, 32'h0);
    // 3: same-index conflict between 0x40 and 0x80
    cycle(0, 1, 32'h80, 1, 0);
    cycle(0, 1, 32'h80, 0, 32'hAAAA_0080);
    cycle(0, 1, 32'h80, 1, 0);
    cycle(0, 1, 32'h40, 1, 0);
    cycle(0, 1, 32'h40, 0, 32'h2001_0005);
    // 4: request dropped and address changed while filling 0x100
    cycle(0, 1, 32'h100, 1, 0);
    cycle(0, 0, 32'h104, 1, 0);
    cycle(0, 0, 32'h104, 0, 32'h0000_0100);
    cycle(0, 1, 32'h104, 1, 0);
    cycle(0, 1, 32'h104, 0, 32'h0000_0104);
    cycle(0, 1, 32'h100, 1, 0);
    // 5: reset in the middle of a fill
    cycle(0, 1, 32'h200, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("t5_iREN_after_rst", {31'b0, iREN}, 32'h0);
    cycle(0, 1, 32'h40, 1, 0);
    cycle(0, 1, 32'h40, 0, 32'h2001_0005);
    // 6: three misses and five hit cycles from reset
    cycle(1, 0, 0, 1, 0);
    cycle(0, 1, 32'h40, 1, 0); cycle(0, 1, 32'h40, 0, 32'h1111_0040);
    cycle(0, 1, 32'h44, 1, 0); cycle(0, 1, 32'h44, 0, 32'h1111_0044);
    cycle(0, 1, 32'h48, 1, 0); cycle(0, 1, 32'h48, 0, 32'h1111_0048);
    repeat (5) cycle(0, 1, 32'h40, 1, 0);
    cycle(0, 0, 0, 1, 0);
`ifdef ICACHE_STATS_EN
    chk("t6_hit_count", hit_count, 32'd5);
    chk("t6_miss_count", miss_count, 32'd3);
`else
    chk("t6_hit_count", hit_count, 32'd0);
    chk("t6_miss_count", miss_count, 32'd0);
`endif
    // Randomized traffic over a small address pool to force hits and conflicts
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      a = ({30'b0, 2'($urandom_range(0, 3))} << 6) |
          ({28'b0, 4'($urandom_range(0, 15))} << 2) |
          {30'b0, 2'($urandom_range(0, 3))};
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8), a,
            ($urandom_range(0, 1) == 1), $urandom);
    end
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
